mem_port_arbiter: RTL and testbench

//  Shares one single-ported 16-bit memory between the instruction-fetch port (IF state)
//  and the data port (MEM state: LW/SW) of the multicycle core.

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/mem_arb_watchdog.sv | 32 +++
 rtl/mem_port_arbiter.sv | 143 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/data memory-port arbiter.
// State codes, port-owner codes and the watchdog counter width.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        RESP = 2'b10
    } arb_state_e;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_D  = 1'b1;

    localparam int CNT_W = 8;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Counts BUSY cycles of one memory access and flags expiry on the last allowed cycle.
// A TIMEOUT of 0 disables expiry, so the access waits for m_ack forever.
module mem_arb_watchdog
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic count,
    output logic expire
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (count) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Expiry is combinational so the FSM can leave BUSY on exactly the TIMEOUT-th cycle.
    assign expire = (TIMEOUT != 0) && count && (cnt_q == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and data load/store.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin tie breaking; default is data-port priority.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              err,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_ack,
    output logic              busy,
    output logic              owner
);

    arb_state_e        state_q;
    logic              m_req_q, m_we_q, owner_q;
    logic [ADDR_W-1:0] m_addr_q;
    logic [DATA_W-1:0] m_wdata_q, if_rdata_q, d_rdata_q;
    logic              if_ack_q, d_ack_q, err_q;
    logic              grant_d;
    logic              wd_expire;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic rr_q;

    // On a tie the port that did not win last time is served; a lone requester always wins.
    always_comb begin
        grant_d = d_req;
        if (if_req && d_req) begin
            grant_d = ~rr_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_q <= OWN_IF;
        end else if (state_q == IDLE && (if_req || d_req)) begin
            rr_q <= grant_d;
        end
    end
`else
    // Data port wins every tie; fetch may starve under back-to-back data traffic.
    always_comb begin
        grant_d = d_req;
    end
`endif

    mem_arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (state_q == IDLE),
        .count   (state_q == BUSY && !m_ack),
        .expire  (wd_expire)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            m_req_q    <= 1'b0;
            m_we_q     <= 1'b0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            owner_q    <= OWN_IF;
            if_ack_q   <= 1'b0;
            d_ack_q    <= 1'b0;
            err_q      <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (if_req || d_req) begin
                        owner_q   <= grant_d;
                        m_req_q   <= 1'b1;
                        m_we_q    <= (grant_d == OWN_D) ? d_we : 1'b0;
                        m_addr_q  <= (grant_d == OWN_D) ? d_addr : if_addr;
                        m_wdata_q <= (grant_d == OWN_D) ? d_wdata : '0;
                        state_q   <= BUSY;
                    end
                end
                BUSY: begin
                    // m_ack takes precedence over a timeout landing on the same cycle.
                    if (m_ack || wd_expire) begin
                        m_req_q <= 1'b0;
                        err_q   <= !m_ack;
                        state_q <= RESP;
                        if (owner_q == OWN_IF) begin
                            if_ack_q   <= 1'b1;
                            if_rdata_q <= m_ack ? m_rdata : '0;
                        end else begin
                            d_ack_q <= 1'b1;
                            if (!m_we_q) begin
                                d_rdata_q <= m_ack ? m_rdata : '0;
                            end
                        end
                    end
                end
                RESP: begin
                    if_ack_q <= 1'b0;
                    d_ack_q  <= 1'b0;
                    err_q    <= 1'b0;
                    state_q  <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign m_req    = m_req_q;
    assign m_we     = m_we_q;
    assign m_addr   = m_addr_q;
    assign m_wdata  = m_wdata_q;
    assign if_ack   = if_ack_q;
    assign d_ack    = d_ack_q;
    assign err      = err_q;
    assign if_rdata = if_rdata_q;
    assign d_rdata  = d_rdata_q;
    assign owner    = owner_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (TIMEOUT=4).
// Expected arbitration order follows MEM_ARB_ROUND_ROBIN_EN when it is defined.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        if_req, d_req, d_we, m_ack;
    logic [15:0] if_addr, d_addr, d_wdata, m_rdata;
    logic        if_ack, d_ack, err, m_req, m_we, busy, owner;
    logic [15:0] if_rdata, d_rdata, m_addr, m_wdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W  (16),
        .DATA_W  (16),
        .TIMEOUT (4)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_ack   (if_ack),
        .if_rdata (if_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_ack    (d_ack),
        .d_rdata  (d_rdata),
        .err      (err),
        .m_req    (m_req),
        .m_we     (m_we),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_rdata  (m_rdata),
        .m_ack    (m_ack),
        .busy     (busy),
        .owner    (owner)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One access from a single requester; ack_k = BUSY cycle carrying m_ack, 0 = never.
    task automatic serve(input logic port_d, input logic we, input logic [15:0] addr,
                         input logic [15:0] wdata, input int ack_k, input logic [15:0] rd,
                         input logic exp_err, input logic [15:0] exp_rdata);
        int n;
        n = (ack_k == 0) ? 4 : ack_k;
        if (port_d) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        tick();
        chk("m_addr", m_addr, addr);
        chk("m_we", m_we, we);
        chk("owner", owner, port_d);
        if (we) chk("m_wdata", m_wdata, wdata);
        for (int k = 1; k <= n; k++) begin
            chk("m_req_busy", m_req, 1'b1);
            chk("busy_busy", busy, 1'b1);
            chk("ack_early", if_ack | d_ack, 1'b0);
            m_ack   = (k == ack_k);
            m_rdata = (k == ack_k) ? rd : 16'hDEAD;
            tick();
        end
        m_ack = 1'b0;
        chk("m_req_resp", m_req, 1'b0);
        chk("own_ack", port_d ? d_ack : if_ack, 1'b1);
        chk("other_ack", port_d ? if_ack : d_ack, 1'b0);
        chk("err", err, exp_err);
        chk("rdata", port_d ? d_rdata : if_rdata, exp_rdata);
        $display("txn port=%s we=%0d addr=%04h wdata=%04h err=%0d rdata=%04h",
                 port_d ? "D" : "I", we, addr, wdata, err, port_d ? d_rdata : if_rdata);
        if_req = 1'b0;
        d_req  = 1'b0;
        tick();
        chk("ack_one_cycle", if_ack | d_ack, 1'b0);
        chk("err_clear", err, 1'b0);
        chk("busy_idle", busy, 1'b0);
    endtask

    initial begin
        logic [4:0] order;
        logic       exp_d;

        reset_n = 1'b0;
        if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        m_ack = 1'b0; m_rdata = '0;
        tick();
        tick();
        chk("rst_m_req", m_req, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_acks", {if_ack, d_ack, err}, 3'b000);
        chk("rst_owner", owner, 1'b0);
        chk("rst_rdata", {if_rdata, d_rdata}, 32'h0);
        chk("rst_m_addr", m_addr, 16'h0);
        reset_n = 1'b1;
        tick();

        // Fetch, m_ack two cycles after m_req rises.
        serve(1'b0, 1'b0, 16'h0004, 16'h0000, 3, 16'h1234, 1'b0, 16'h1234);
        // Store then load of the same word; fetch data must not move.
        serve(1'b1, 1'b1, 16'h0010, 16'hBEEF, 1, 16'h0000, 1'b0, 16'h0000);
        serve(1'b1, 1'b0, 16'h0010, 16'h0000, 2, 16'hBEEF, 1'b0, 16'hBEEF);
        chk("if_rdata_held", if_rdata, 16'h1234);

        // Contention from a fresh reset so the round-robin pointer starts at 0.
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
`ifdef MEM_ARB_ROUND_ROBIN_EN
        order = 5'b00101;
`else
        order = 5'b01111;
`endif
        if_req = 1'b1; if_addr = 16'h0100;
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0200;
        for (int i = 0; i < 5; i++) begin
            exp_d = order[i];
            tick();
            chk("arb_owner", owner, exp_d);
            chk("arb_m_addr", m_addr, exp_d ? 16'h0200 : 16'h0100);
            m_ack = 1'b1;
            m_rdata = 16'h0A00 + 16'(i);
            tick();
            m_ack = 1'b0;
            chk("arb_d_ack", d_ack, exp_d);
            chk("arb_if_ack", if_ack, !exp_d);
            $display("txn arb %0d winner=%s m_addr=%04h", i, owner ? "D" : "I", m_addr);
            if (i == 3) d_req = 1'b0;
            if (i == 4) if_req = 1'b0;
            tick();
        end
        chk("arb_idle", busy, 1'b0);

        // Timeout with no m_ack, then m_ack on the very last allowed cycle.
        serve(1'b1, 1'b0, 16'h0040, 16'h0000, 0, 16'h0000, 1'b1, 16'h0000);
        serve(1'b1, 1'b0, 16'h0040, 16'h0000, 4, 16'h00AA, 1'b0, 16'h00AA);

        // Reset in the second BUSY cycle abandons the access.
        if_req = 1'b1; if_addr = 16'h0020;
        tick();
        tick();
        chk("pre_rst_m_req", m_req, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("rst_mid_m_req", m_req, 1'b0);
        chk("rst_mid_busy", busy, 1'b0);
        if_req = 1'b0;
        tick();
        chk("rst_mid_ack", {if_ack, d_ack}, 2'b00);
        reset_n = 1'b1;
        tick();
        chk("post_rst_ack", {if_ack, d_ack}, 2'b00);
        chk("post_rst_busy", busy, 1'b0);
        serve(1'b0, 1'b0, 16'h0030, 16'h0000, 1, 16'h5555, 1'b0, 16'h5555);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
